// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates, active-video flag and syncs,
// plus syncs/blank delayed to match the RGB pixel pipeline.
module video_timing_gen #(
  parameter int H_ACTIVE        = 1280,
  parameter int H_FP            = 48,
  parameter int H_SYNC          = 112,
  parameter int H_BP            = 248,
  parameter int V_ACTIVE        = 1024,
  parameter int V_FP            = 1,
  parameter int V_SYNC          = 3,
  parameter int V_BP            = 38,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int PIPE_DELAY      = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEGIN   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEGIN   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

  if (V_ACTIVE < 1 || V_ACTIVE > 1024 || H_ACTIVE < 1 || H_TOTAL > 2047 ||
      V_TOTAL > 2047 || PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_bad_params
    $error("video_timing_gen: timing parameters out of range");
  end

  logic [10:0] r_hc;
  logic [10:0] r_vc;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic        r_valid;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_line_start;
  logic        r_frame_start;

  logic w_h_act;
  logic w_v_act;
  logic w_hs_win;
  logic w_vs_win;
  logic w_h_wrap;

  assign w_h_act  = r_hc < H_ACT_END;
  assign w_v_act  = r_vc < V_ACT_END;
  assign w_hs_win = (r_hc >= HS_BEGIN) && (r_hc < HS_END);
  assign w_vs_win = (r_vc >= VS_BEGIN) && (r_vc < VS_END);
  assign w_h_wrap = r_hc == H_LAST;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_valid       <= 1'b0;
      r_hsync       <= SYNC_IDLE;
      r_vsync       <= SYNC_IDLE;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_h_wrap) begin
        r_hc <= '0;
        r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 11'd1;
      end else begin
        r_hc <= r_hc + 11'd1;
      end
      // Outputs decode the pre-increment counters, so they trail hc/vc by one clock.
      r_x           <= w_h_act ? r_hc : '0;
      r_y           <= w_v_act ? r_vc[9:0] : '0;
      r_valid       <= w_h_act & w_v_act;
      r_hsync       <= w_hs_win ^ SYNC_IDLE;
      r_vsync       <= w_vs_win ^ SYNC_IDLE;
      r_line_start  <= r_hc == '0;
      r_frame_start <= (r_hc == '0) && (r_vc == '0);
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign valid       = r_valid;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

  logic [2:0] w_tap;
  assign w_tap = {r_hsync, r_vsync, ~r_valid};

  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign {hsync_out, vsync_out, blank_out} = w_tap;
  end else if (PIPE_DELAY > 0) begin : g_pipe
    localparam int PD = PIPE_DELAY;
    localparam logic [2:0] RST_TAP = {SYNC_IDLE, SYNC_IDLE, 1'b1};

    logic [3*PD-1:0] r_pipe;
    logic [3*PD+2:0] w_chain;

    // Newest tap in the low bits; the oldest stage sits at the top of r_pipe.
    assign w_chain = {r_pipe, w_tap};

    always_ff @(posedge clk) begin
      if (reset) r_pipe <= {PD{RST_TAP}};
      else       r_pipe <= w_chain[3*PD-1:0];
    end

    assign {hsync_out, vsync_out, blank_out} = r_pipe[3*PD-1 -: 3];
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 1280x1024 timing with PIPE_DELAY=2, and a 14x7 small
// timing build (active-high syncs, PIPE_DELAY=0) traced over a full frame.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [10:0] a_x, b_x;
  logic [9:0]  a_y, b_y;
  logic a_valid, a_hsync, a_vsync, a_ls, a_fs, a_hso, a_vso, a_bo;
  logic b_valid, b_hsync, b_vsync, b_ls, b_fs, b_hso, b_vso, b_bo;

  video_timing_gen #(.PIPE_DELAY(2)) u_dut (
    .clk(clk), .reset(rst_a), .x(a_x), .y(a_y), .valid(a_valid),
    .hsync(a_hsync), .vsync(a_vsync), .line_start(a_ls), .frame_start(a_fs),
    .hsync_out(a_hso), .vsync_out(a_vso), .blank_out(a_bo)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_ACTIVE_LOW(0), .PIPE_DELAY(0)
  ) u_small (
    .clk(clk), .reset(rst_b), .x(b_x), .y(b_y), .valid(b_valid),
    .hsync(b_hsync), .vsync(b_vsync), .line_start(b_ls), .frame_start(b_fs),
    .hsync_out(b_hso), .vsync_out(b_vso), .blank_out(b_bo)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          n;
    logic [10:0] x;
    logic [9:0]  y;
    logic        v, hs, vs, ls, fs;
  } vec_t;

  function automatic vec_t mk(input int n, input int xv, input int yv,
                              input logic v, input logic hs, input logic vs,
                              input logic ls, input logic fs);
    vec_t r;
    r.n = n; r.x = 11'(xv); r.y = 10'(yv);
    r.v = v; r.hs = hs; r.vs = vs; r.ls = ls; r.fs = fs;
    return r;
  endfunction

  localparam int NV = 17;
  vec_t tbl[NV];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int first_inval, hs_low, hs_first, x_err, pipe_err, x_at_1280;
    int ls_n[$];
    int ls_y[$];
    logic pv1, pv2, ph1, ph2, ps1, ps2;
    int ti, hs_hi, vs_hi, v_cnt, ls_cnt, fs_cnt, p0_err;
    vec_t e;

    // small-timing frame, n = linear counter index (line*14 + hc) shown at the outputs
    tbl[0]  = mk(0,  0, 0, 1, 0, 0, 1, 1);
    tbl[1]  = mk(7,  7, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(8,  0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(10, 0, 0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(11, 0, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(12, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(13, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(14, 0, 1, 1, 0, 0, 1, 0);
    tbl[8]  = mk(17, 3, 1, 1, 0, 0, 0, 0);
    tbl[9]  = mk(45, 3, 3, 1, 0, 0, 0, 0);
    tbl[10] = mk(53, 0, 3, 0, 1, 0, 0, 0);
    tbl[11] = mk(56, 0, 0, 0, 0, 0, 1, 0);
    tbl[12] = mk(70, 0, 0, 0, 0, 1, 1, 0);
    tbl[13] = mk(81, 0, 0, 0, 1, 1, 0, 0);
    tbl[14] = mk(84, 0, 0, 0, 0, 0, 1, 0);
    tbl[15] = mk(97, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(98, 0, 0, 1, 0, 0, 1, 1);

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;

    chk("rst.x",        32'(a_x), 0);
    chk("rst.y",        32'(a_y), 0);
    chk("rst.valid",    32'(a_valid), 0);
    chk("rst.line_start",  32'(a_ls), 0);
    chk("rst.frame_start", 32'(a_fs), 0);
    chk("rst.syncs",    32'({a_hsync, a_vsync, a_hso, a_vso, a_bo}), 32'h1f);

    step();
    chk("rel1.flags", 32'({a_valid, a_ls, a_fs, a_hsync, a_vsync}), 32'h1f);
    chk("rel1.xy",    32'({a_x, a_y}), 0);
    chk("rel1.blank_out", 32'(a_bo), 1);

    first_inval = -1; hs_low = 0; hs_first = -1; x_err = 0; pipe_err = 0; x_at_1280 = -1;
    pv1 = 1'b0; pv2 = 1'b0; ph1 = 1'b1; ph2 = 1'b1; ps1 = 1'b1; ps2 = 1'b1;
    for (int n = 0; n < 3 * 1688 + 4; n++) begin
      int hc;
      hc = n % 1688;
      if (hc < 1280) begin
        if (a_x !== 11'(hc)) x_err++;
      end else if (a_x !== 11'd0) x_err++;
      if (n == 1280) x_at_1280 = int'(a_x);
      if (first_inval < 0 && a_valid !== 1'b1) first_inval = n;
      if (n < 1688 && a_hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = n;
      end
      if (a_ls === 1'b1) begin
        ls_n.push_back(n);
        ls_y.push_back(int'(a_y));
      end
      if (a_bo !== ~pv2 || a_hso !== ph2 || a_vso !== ps2) pipe_err++;
      pv2 = pv1; pv1 = a_valid;
      ph2 = ph1; ph1 = a_hsync;
      ps2 = ps1; ps1 = a_vsync;
      step();
    end
    chk("line.first_invalid", 32'(first_inval), 1280);
    chk("line.x_at_1280",     32'(x_at_1280), 0);
    chk("line.x_errors",      32'(x_err), 0);
    chk("line.hsync_low_len", 32'(hs_low), 112);
    chk("line.hsync_first",   32'(hs_first), 1328);
    chk("line.ls_count",      32'(ls_n.size()), 4);
    if (ls_n.size() == 4) begin
      chk("line.ls1_pos", 32'(ls_n[1]), 1688);
      chk("line.ls2_pos", 32'(ls_n[2]), 3376);
      chk("line.ls3_pos", 32'(ls_n[3]), 5064);
      chk("line.ls1_y",   32'(ls_y[1]), 1);
      chk("line.ls2_y",   32'(ls_y[2]), 2);
      chk("line.ls3_y",   32'(ls_y[3]), 3);
    end
    chk("pipe2.align_errors", 32'(pipe_err), 0);

    // now showing n = 5068; advance to hc=700 on line 3, then reset mid-frame
    repeat (3 * 1688 + 700 - 5068) step();
    chk("mid.pre_xy", 32'({a_x, a_y}), 32'({11'd700, 10'd3}));
    chk("mid.pre_blank_out", 32'(a_bo), 0);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("mid.rst_xy",    32'({a_x, a_y}), 0);
    chk("mid.rst_flags", 32'({a_valid, a_ls, a_fs}), 0);
    chk("mid.rst_syncs", 32'({a_hsync, a_vsync, a_hso, a_vso, a_bo}), 32'h1f);
    step();
    chk("mid.rel_flags", 32'({a_valid, a_ls, a_fs}), 32'h7);
    chk("mid.rel_xy",    32'({a_x, a_y}), 0);
    chk("mid.rel_blank_out", 32'(a_bo), 1);

    rst_b = 1'b0;
    chk("small.rst", 32'({b_x, b_y, b_valid, b_hsync, b_vsync, b_ls, b_fs, b_hso, b_vso, b_bo}), 1);
    step();

    ti = 0; hs_hi = 0; vs_hi = 0; v_cnt = 0; ls_cnt = 0; fs_cnt = 0; p0_err = 0;
    for (int n = 0; n <= 98; n++) begin
      if (n < 98) begin
        if (b_hsync === 1'b1) hs_hi++;
        if (b_vsync === 1'b1) vs_hi++;
        if (b_valid === 1'b1) v_cnt++;
        if (b_ls === 1'b1) ls_cnt++;
        if (b_fs === 1'b1) fs_cnt++;
        if (b_hso !== b_hsync || b_vso !== b_vsync || b_bo !== ~b_valid) p0_err++;
      end
      while (ti < NV && tbl[ti].n == n) begin
        e = tbl[ti];
        chk($sformatf("small.n%0d", n),
            32'({b_x, b_y, b_valid, b_hsync, b_vsync, b_ls, b_fs, b_hso, b_vso, b_bo}),
            32'({e.x, e.y, e.v, e.hs, e.vs, e.ls, e.fs, e.hs, e.vs, ~e.v}));
        ti++;
      end
      if (n < 98) step();
    end
    chk("small.hsync_clocks", 32'(hs_hi), 14);
    chk("small.vsync_clocks", 32'(vs_hi), 14);
    chk("small.valid_clocks", 32'(v_cnt), 32);
    chk("small.line_starts",  32'(ls_cnt), 7);
    chk("small.frame_starts", 32'(fs_cnt), 1);
    chk("small.pipe0_errors", 32'(p0_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the wave display top level.
- Produces the pixel coordinates (x, y), the active-video flag (valid) and the sync signals for a 1280x1024 display; x, y, valid and vsync drive wave_display_top.
- Also emits delayed copies of hsync, vsync and blank, matched to the pixel-pipeline latency of the RGB path, for the video encoder.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width (clocks)
- H_BP, 248, horizontal back porch (clocks); H_TOTAL = 1688
- V_ACTIVE, 1024, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 38, vertical back porch (lines); V_TOTAL = 1066
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync driven low during the sync pulse
- PIPE_DELAY, 2, clocks of delay on hsync_out/vsync_out/blank_out (0..8)

Ports:
- clk  in  1  pixel clock (108 MHz at default timing)
- reset  in  1  synchronous, active-high reset
- x  out  11  horizontal pixel coordinate, 0..H_ACTIVE-1 in the active region, 0 elsewhere
- y  out  10  vertical pixel coordinate, 0..V_ACTIVE-1 in the active region, 0 elsewhere
- valid  out  1  high when both x and y are in the active region
- hsync  out  1  horizontal sync, aligned with x/y
- vsync  out  1  vertical sync, aligned with x/y
- line_start  out  1  one-clock pulse at hc==0 on every line
- frame_start  out  1  one-clock pulse at hc==0, vc==0
- hsync_out  out  1  hsync delayed by PIPE_DELAY
- vsync_out  out  1  vsync delayed by PIPE_DELAY
- blank_out  out  1  ~valid delayed by PIPE_DELAY

Behaviour:
- Internal counters are 11-bit:
  - hc counts 0..H_TOTAL-1 and wraps to 0.
  - vc increments when hc wraps, counts 0..V_TOTAL-1 and wraps to 0 on the same clock hc wraps from H_TOTAL-1.
- All outputs are registered and decoded from the current counter values, so outputs lag the counters by 1 clock.
- Decode:
  - h_act = hc < H_ACTIVE; v_act = vc < V_ACTIVE; valid = h_act & v_act.
  - x = h_act ? hc : 0.
  - y = v_act ? vc[9:0] : 0. x/y are not zeroed by the other axis, so y holds during horizontal blanking.
  - Horizontal sync window: H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (default hc 1328..1439).
  - Vertical sync window: V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (default vc 1025..1027), for all hc on those lines.
  - Output level is asserted = ~SYNC_ACTIVE_LOW inside the window, the inverse outside.
- Reset (synchronous, any time, including mid-frame):
  - hc = 0, vc = 0.
  - x = 0, y = 0, valid = 0, line_start = 0, frame_start = 0.
  - hsync/vsync at the deasserted level.
  - All delay-line stages cleared: blank_out = 1, syncs deasserted.
- First clock after reset deasserts: counters at 0, outputs still at reset values.
- Second clock: x=0, y=0, valid=1, line_start=1, frame_start=1.
- Delay line:
  - PIPE_DELAY-stage shift register of {hsync, vsync, ~valid}.
  - PIPE_DELAY=0: hsync_out/vsync_out/blank_out equal the undelayed signals combinationally.
  - After reset the delayed outputs stay at reset values for PIPE_DELAY clocks beyond the undelayed ones.
- Frame period is exactly H_TOTAL*V_TOTAL clocks (1,799,408 at default); no drift or gaps.
- Timing parameters are elaboration-time constants only; no run-time reprogramming.
- Width rule: V_ACTIVE <= 1024 and H_TOTAL, V_TOTAL <= 2047 are required. Out-of-range values are flagged at elaboration by an assertion.
- vsync level drives wave_display_top directly. With default SYNC_ACTIVE_LOW=1, its ~vsync idle strobe is high only during the 3 vertical-sync lines.

Test Plan:
- Reset, then release:
  - Cycle 1 shows reset values.
  - Cycle 2 shows x=0, y=0, valid=1, frame_start=1, hsync=vsync=1, blank_out=1 until cycle 2+PIPE_DELAY.
- Line wrap:
  - x counts 0..1279 with valid=1.
  - At hc=1280, valid=0 and x=0.
  - hsync is low for exactly 112 clocks starting at hc=1328.
  - line_start pulses every 1688 clocks; y increments by 1 at each line_start.
- Frame wrap:
  - y reaches 1023, then valid stays 0 for 42 lines.
  - vsync is low for exactly 3 x 1688 clocks starting on line 1025.
  - frame_start recurs every 1,799,408 clocks.
- Reset mid-frame at hc=700, vc=500: outputs return to reset values next clock, and frame_start fires on the second clock after release.
- Delay alignment with PIPE_DELAY=2 and PIPE_DELAY=0: blank_out equals ~valid shifted by exactly 2 (resp. 0) clocks; same for the syncs.
- Small-timing build (H: 8/2/2/2, V: 4/1/1/1, SYNC_ACTIVE_LOW=0): full-frame trace matches the hand-computed 14x7 = 98-clock pattern, with syncs active-high.
